frame_capture_sched: RTL and testbench
======================================

// Module: frame_capture_sched
// PURPOSE
//  Sequences ball_ram frame capture and flipdot transmission. Decides which video frames are written
//  into ball_ram (whole frames only, aligned to v_sync), then starts serial_stream_gen on the captured
//  frame and holds off further capture until the transmission completes or times out.
//  Sits between the VGA timing signals and the ball_ram write enable / stream generator start.
// PARAMETERS
//  FRAME_DIV   4        in auto mode, capture one frame out of every FRAME_DIV frame starts (1..255)
//  TX_TIMEOUT  2000000  ball_clock cycles allowed in WAIT_TX before abort (>=2)
//  TO_W        21       width of timeout counter; must hold TX_TIMEOUT
// PORTS
//  ball_clock    in   1   pixel clock; all logic on rising edge
//  reset         in   1   synchronous, active-high
//  v_sync        in   1   high during vertical active region; rising edge = frame start
//  active_area   in   1   high on active pixels
//  freeze        in   1   level; inhibits arming new captures (current capture completes)
//  auto_mode     in   1   1 = periodic capture per FRAME_DIV; 0 = capture only on capture_req
//  capture_req   in   1   one-cycle request; latched until serviced
//  tx_done       in   1   one-cycle pulse from stream generator: frame sent
//  ram_wren      out  1   ball_ram write enable
//  tx_start      out  1   one-cycle pulse to stream generator
//  frame_ready   out  1   high from end of capture until tx_done/timeout
//  timeout_err   out  1   sticky; set on TX timeout, cleared by reset or next successful tx_done
//  frame_cnt     out  16  count of completed captures, wraps 0xFFFF->0
//  state_dbg     out  3   encoded current state (for EX_IO)
// BEHAVIOUR
//  - Reset: state=IDLE; ram_wren, tx_start, frame_ready, timeout_err=0; frame_cnt=0; req latch=0;
//    frame divider counter=0. Reset mid-capture drops ram_wren on the next cycle; partial frame unused.
//  - vs_d = v_sync registered; vs_rise = v_sync & ~vs_d; vs_fall = ~v_sync & vs_d (1-cycle detect).
//  - Divider: on every vs_rise, div_cnt increments, wraps FRAME_DIV-1 -> 0; div_hit = (div_cnt==0) at vs_rise.
//  - req latch: set by capture_req in any state; cleared on transition ARM->CAPTURE. Set+clear same cycle: stays set.
//  - States (state_dbg code):
//    IDLE(0): if ~freeze & (req latch | auto_mode) -> ARM.
//    ARM(1): wait for vs_rise. On vs_rise: if freeze -> IDLE; else if req latch | (auto_mode & div_hit)
//      -> CAPTURE; else stay. Never enters CAPTURE mid-frame (v_sync already high is not a start).
//    CAPTURE(2): ram_wren = active_area (combinational AND with registered state, no extra latency).
//      freeze ignored. On vs_fall -> DONE.
//    DONE(3): one cycle; tx_start=1; frame_ready<=1; frame_cnt<=frame_cnt+1 -> WAIT_TX.
//    WAIT_TX(4): to_cnt increments each cycle from 0. tx_done -> IDLE, frame_ready<=0, timeout_err<=0.
//      to_cnt==TX_TIMEOUT-1 without tx_done -> IDLE, frame_ready<=0, timeout_err<=1.
//      tx_done and timeout same cycle: tx_done wins (no error).
//  - tx_done outside WAIT_TX ignored. vs_rise in WAIT_TX/DONE ignored except div_cnt advance.
//  - ram_wren is 0 in every state except CAPTURE.
//  - Exactly one tx_start per captured frame; ram_wren never asserted while frame_ready=1.
// TESTING
//  1. auto_mode=1, FRAME_DIV=4, tx_done 100 cycles after tx_start, 12 frames -> captures on frames 0,4,8;
//     ram_wren high only on active_area of those frames; frame_cnt=3; 3 tx_start pulses.
//  2. auto_mode=0, capture_req pulse mid-frame -> no wren in current frame; capture on next frame start;
//     one tx_start at its vs_fall+1; frame_cnt=1.
//  3. freeze=1 asserted during CAPTURE -> capture completes, tx_start issued; with freeze held no new ARM.
//  4. No tx_done, TX_TIMEOUT=50 -> IDLE 50 cycles after entering WAIT_TX, timeout_err=1, frame_ready=0;
//     next capture+tx_done clears timeout_err.
//  5. Start with v_sync already high when entering ARM -> no capture until next rising edge.
//  6. Reset asserted mid-CAPTURE -> ram_wren=0, state_dbg=0, frame_cnt=0 one cycle after reset sampled.

Source files
------------

// File: rtl/frame_capture_sched_if.sv
// Handshake bundle between the VGA timing / control side and the frame capture scheduler.
interface frame_capture_sched_if;
  logic        v_sync;
  logic        active_area;
  logic        freeze;
  logic        auto_mode;
  logic        capture_req;
  logic        tx_done;
  logic        ram_wren;
  logic        tx_start;
  logic        frame_ready;
  logic        timeout_err;
  logic [15:0] frame_cnt;
  logic [2:0]  state_dbg;

  modport master (
    output v_sync, active_area, freeze, auto_mode, capture_req, tx_done,
    input  ram_wren, tx_start, frame_ready, timeout_err, frame_cnt, state_dbg
  );

  modport slave (
    input  v_sync, active_area, freeze, auto_mode, capture_req, tx_done,
    output ram_wren, tx_start, frame_ready, timeout_err, frame_cnt, state_dbg
  );
endinterface

// File: rtl/frame_capture_sched.sv
// Chooses which whole video frames are written to ball_ram and launches the flipdot stream
// on each captured frame, holding off new captures until transmission finishes or times out.
module frame_capture_sched #(
  parameter int FRAME_DIV  = 4,
  parameter int TX_TIMEOUT = 2000000,
  parameter int TO_W       = 21
) (
  input  logic                 ball_clock,
  input  logic                 reset,
  frame_capture_sched_if.slave bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARM     = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_WAIT_TX = 3'd4;

  localparam logic [7:0]      DIV_LAST = 8'(FRAME_DIV - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TX_TIMEOUT - 1);

  logic [2:0]      state;
  logic            vs_d;
  logic            vs_rise;
  logic            vs_fall;
  logic [7:0]      div_cnt;
  logic            div_hit;
  logic            req_lat;
  logic            arm_go;
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;
  logic            frame_ready;
  logic            timeout_err;
  logic [15:0]     frame_cnt;

  // vs_d simply follows v_sync; a high v_sync at reset release must not look like a frame start.
  always_ff @(posedge ball_clock) begin
    vs_d <= bus.v_sync;
  end

  assign vs_rise = bus.v_sync & ~vs_d;
  assign vs_fall = ~bus.v_sync & vs_d;
  assign div_hit = (div_cnt == 8'd0);
  assign to_hit  = (to_cnt == TO_LAST);
  assign arm_go  = (state == S_ARM) & vs_rise & ~bus.freeze &
                   (req_lat | (bus.auto_mode & div_hit));

  // The divider counts every frame start regardless of state so the auto cadence stays fixed.
  always_ff @(posedge ball_clock) begin
    if (reset) begin
      div_cnt <= 8'd0;
    end else if (vs_rise) begin
      div_cnt <= (div_cnt == DIV_LAST) ? 8'd0 : div_cnt + 8'd1;
    end
  end

  // A new request in the same cycle as the latch is consumed wins, so it is never lost.
  always_ff @(posedge ball_clock) begin
    if (reset) begin
      req_lat <= 1'b0;
    end else if (bus.capture_req) begin
      req_lat <= 1'b1;
    end else if (arm_go) begin
      req_lat <= 1'b0;
    end
  end

  always_ff @(posedge ball_clock) begin
    if (reset) begin
      state       <= S_IDLE;
      frame_ready <= 1'b0;
      timeout_err <= 1'b0;
      frame_cnt   <= 16'd0;
      to_cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!bus.freeze && (req_lat || bus.auto_mode)) begin
            state <= S_ARM;
          end
        end
        S_ARM: begin
          if (vs_rise) begin
            if (bus.freeze) begin
              state <= S_IDLE;
            end else if (arm_go) begin
              state <= S_CAPTURE;
            end
          end
        end
        S_CAPTURE: begin
          if (vs_fall) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          frame_ready <= 1'b1;
          frame_cnt   <= frame_cnt + 16'd1;
          to_cnt      <= '0;
          state       <= S_WAIT_TX;
        end
        S_WAIT_TX: begin
          // tx_done takes priority over a coincident timeout.
          if (bus.tx_done) begin
            frame_ready <= 1'b0;
            timeout_err <= 1'b0;
            state       <= S_IDLE;
          end else if (to_hit) begin
            frame_ready <= 1'b0;
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ram_wren    = (state == S_CAPTURE) & bus.active_area;
  assign bus.tx_start    = (state == S_DONE);
  assign bus.frame_ready = frame_ready;
  assign bus.timeout_err = timeout_err;
  assign bus.frame_cnt   = frame_cnt;
  assign bus.state_dbg   = state;

endmodule

// File: tb/tb_frame_capture_sched.sv
// Scoreboard bench for frame_capture_sched: stimulus queues expected captures, a monitor checks each tx_start.
module tb_frame_capture_sched;

  localparam int FRAME_DIV  = 4;
  localparam int TX_TIMEOUT = 50;
  localparam int TO_W       = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  frame_capture_sched_if bus_if ();

  frame_capture_sched #(
    .FRAME_DIV (FRAME_DIV),
    .TX_TIMEOUT(TX_TIMEOUT),
    .TO_W      (TO_W)
  ) dut (
    .ball_clock(clk),
    .reset     (rst),
    .bus       (bus_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int frm;
    int wren;
    int cnt;
    int rdy;
    int terr;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cur_frame = -1;
  int   next_frame = 0;
  int   resp_delay = 40;

  int   wren_acc = 0;
  int   rdy_acc = 0;
  bit   cur_v = 1'b0;
  bit   chk_next = 1'b0;
  bit   prev_rdy = 1'b0;
  exp_t cur;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void expect_cap(input int frm, input int cnt, input int rdy, input int terr);
    exp_t e;
    e.frm  = frm;
    e.wren = 16;
    e.cnt  = cnt;
    e.rdy  = rdy;
    e.terr = terr;
    exp_q.push_back(e);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One video frame: 24 cycles v_sync high (active_area on 4..19), 8 cycles low.
  task automatic frame(input int req_at, input int frz_at, input logic frz_val, input int rst_at);
    cur_frame = next_frame;
    next_frame++;
    for (int i = 0; i < 24; i++) begin
      if (i == rst_at) chk("precap_state", int'(bus_if.state_dbg), 2);
      bus_if.v_sync      = 1'b1;
      bus_if.active_area = (i >= 4 && i < 20);
      bus_if.capture_req = (i == req_at);
      if (i == frz_at) bus_if.freeze = frz_val;
      rst = (i == rst_at);
      step();
      if (i == rst_at) begin
        chk("rst_mid_wren", int'(bus_if.ram_wren), 0);
        chk("rst_mid_state", int'(bus_if.state_dbg), 0);
        chk("rst_mid_frame_cnt", int'(bus_if.frame_cnt), 0);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus_if.v_sync      = 1'b0;
      bus_if.active_area = 1'b0;
      bus_if.capture_req = 1'b0;
      step();
    end
  endtask

  task automatic do_reset();
    rst                = 1'b1;
    bus_if.v_sync      = 1'b0;
    bus_if.active_area = 1'b0;
    bus_if.capture_req = 1'b0;
    step();
    step();
    chk("reset_state", int'(bus_if.state_dbg), 0);
    chk("reset_wren", int'(bus_if.ram_wren), 0);
    chk("reset_tx_start", int'(bus_if.tx_start), 0);
    chk("reset_frame_ready", int'(bus_if.frame_ready), 0);
    chk("reset_timeout_err", int'(bus_if.timeout_err), 0);
    chk("reset_frame_cnt", int'(bus_if.frame_cnt), 0);
    rst = 1'b0;
    repeat (4) step();
  endtask

  // Stream generator model: pulses tx_done resp_delay cycles after tx_start (0 = never).
  initial begin
    bus_if.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_if.tx_start && resp_delay > 0) begin
        repeat (resp_delay) @(posedge clk);
        #1 bus_if.tx_done = 1'b1;
        @(posedge clk);
        #1 bus_if.tx_done = 1'b0;
      end
    end
  end

  // Monitor: pops an expectation on every tx_start and follows it until frame_ready drops.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        wren_acc = 0;
        cur_v    = 1'b0;
        chk_next = 1'b0;
        prev_rdy = 1'b0;
      end else begin
        if (chk_next) begin
          chk("cnt_after_start", int'(bus_if.frame_cnt), (cur.cnt + 1) % 65536);
          chk("ready_after_start", int'(bus_if.frame_ready), 1);
          chk_next = 1'b0;
        end
        if (cur_v && prev_rdy && !bus_if.frame_ready) begin
          chk("ready_cycles", rdy_acc, cur.rdy);
          chk("timeout_err_at_end", int'(bus_if.timeout_err), cur.terr);
          cur_v = 1'b0;
        end
        if (bus_if.frame_ready) rdy_acc++;
        if (bus_if.ram_wren) begin
          wren_acc++;
          chk("wren_vs_ready", int'(bus_if.frame_ready), 0);
          chk("wren_vs_active", int'(bus_if.active_area), 1);
        end
        if (bus_if.tx_start) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_tx_start: actual frame=%0d required=none", cur_frame);
          end else begin
            cur = exp_q.pop_front();
            chk("cap_frame", cur_frame, cur.frm);
            chk("wren_cycles", wren_acc, cur.wren);
            chk("cnt_at_start", int'(bus_if.frame_cnt), cur.cnt);
            cur_v    = 1'b1;
            chk_next = 1'b1;
            rdy_acc  = 0;
          end
          wren_acc = 0;
        end
        prev_rdy = bus_if.frame_ready;
      end
    end
  end

  initial begin
    bus_if.v_sync      = 1'b0;
    bus_if.active_area = 1'b0;
    bus_if.freeze      = 1'b0;
    bus_if.auto_mode   = 1'b0;
    bus_if.capture_req = 1'b0;

    // Auto mode, divide by 4: frames 0, 4 and 8 of twelve are captured.
    bus_if.auto_mode = 1'b1;
    do_reset();
    expect_cap(next_frame + 0, 0, 40, 0);
    expect_cap(next_frame + 4, 1, 40, 0);
    expect_cap(next_frame + 8, 2, 40, 0);
    repeat (12) frame(-1, -1, 1'b0, -1);
    chk("t1_frame_cnt", int'(bus_if.frame_cnt), 3);

    // Manual request mid-frame: capture waits for the next frame start.
    bus_if.auto_mode = 1'b0;
    do_reset();
    frame(10, -1, 1'b0, -1);
    expect_cap(next_frame, 0, 40, 0);
    repeat (3) frame(-1, -1, 1'b0, -1);
    chk("t2_frame_cnt", int'(bus_if.frame_cnt), 1);
    chk("t2_idle", int'(bus_if.state_dbg), 0);

    // Freeze during capture: frame completes; held freeze blocks a pending request.
    do_reset();
    frame(10, -1, 1'b0, -1);
    expect_cap(next_frame, 0, 40, 0);
    frame(-1, 10, 1'b1, -1);
    frame(10, -1, 1'b0, -1);
    frame(-1, -1, 1'b0, -1);
    chk("t3_frozen_state", int'(bus_if.state_dbg), 0);
    chk("t3_frozen_cnt", int'(bus_if.frame_cnt), 1);
    chk("t3_frozen_ready", int'(bus_if.frame_ready), 0);
    frame(-1, 0, 1'b0, -1);
    expect_cap(next_frame, 1, 40, 0);
    repeat (3) frame(-1, -1, 1'b0, -1);
    chk("t3_frame_cnt", int'(bus_if.frame_cnt), 2);

    // Reset in the middle of a capture.
    frame(10, -1, 1'b0, -1);
    frame(-1, -1, 1'b0, 12);
    frame(-1, -1, 1'b0, -1);
    chk("t6_after_state", int'(bus_if.state_dbg), 0);
    chk("t6_after_cnt", int'(bus_if.frame_cnt), 0);

    // Transmission timeout, then a successful transmission clears the error.
    resp_delay = 0;
    frame(10, -1, 1'b0, -1);
    expect_cap(next_frame, 0, 50, 1);
    frame(-1, -1, 1'b0, -1);
    frame(-1, -1, 1'b0, -1);
    frame(20, -1, 1'b0, -1);
    chk("t4_timeout_err", int'(bus_if.timeout_err), 1);
    chk("t4_ready_low", int'(bus_if.frame_ready), 0);
    chk("t4_armed", int'(bus_if.state_dbg), 1);
    resp_delay = 40;
    expect_cap(next_frame, 1, 40, 0);
    repeat (3) frame(-1, -1, 1'b0, -1);
    chk("t4_err_cleared", int'(bus_if.timeout_err), 0);
    chk("t4_frame_cnt", int'(bus_if.frame_cnt), 2);

    // Arming while v_sync is already high: no capture until a real frame start hits the divider.
    bus_if.freeze    = 1'b1;
    bus_if.auto_mode = 1'b1;
    do_reset();
    frame(-1, 10, 1'b0, -1);
    repeat (3) frame(-1, -1, 1'b0, -1);
    chk("t5_no_early_capture", int'(bus_if.frame_cnt), 0);
    expect_cap(next_frame, 0, 40, 0);
    repeat (3) frame(-1, -1, 1'b0, -1);
    chk("t5_frame_cnt", int'(bus_if.frame_cnt), 1);

    chk("queue_drained", exp_q.size(), 0);
    chk("no_pending_tx", int'(cur_v), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
